// File: rtl/fetch_unit_if.sv
// Purpose : handshake/bus bundle between the fetch stage, instruction memory, branch unit and decode.
// Latency : none; wires only.
// Backpressure: decode throttles the fetch queue through instr_valid/instr_ready.
// Ports   : master = fetch_unit side (drives imem_addr, instr_valid, instr, instr_pc, halted);
//           slave  = environment side (drives imem_instr, redirect_*, halt_req, instr_ready).
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  halt_req;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  halted;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_addr,
        input  halt_req,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_addr,
        output halt_req,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Purpose : owns the PC, reads the combinational instruction memory and queues {pc, instr} for decode.
// Latency : 1 cycle fetch-to-head on an empty queue; 2-cycle redirect penalty.
// Backpressure: instr_ready low fills the queue, then fetch_pc holds until a pop frees a slot.
// Ports   : clk, rst (sync, active-high); bus (fetch_unit_if.master) carries imem address/data,
//           redirect and halt requests, the decode valid/ready handshake with instr/instr_pc, and halted.
module fetch_unit #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 12,
    parameter int          FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    entry_t                queue_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  not_full;
    logic                  pop;
    logic                  push;
    entry_t                head;

    assign not_full = (count < CNT_W'(FIFO_DEPTH));
    assign pop      = (count != '0) && bus.instr_ready;
    // A pop in the same cycle frees a slot, so a full queue still fetches
    // when decode is draining it.
    assign push     = (state_q == RUN) && !bus.redirect_valid && !bus.halt_req
                      && (not_full || pop);

    // Next-state logic: redirect wins from either state and may land in HALT
    // when a halt arrives alongside it; otherwise only RUN reacts to halt_req.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = bus.halt_req ? HALT : RUN;
        end else if ((state_q == RUN) && bus.halt_req) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, pointers and occupancy. A redirect discards everything queued,
    // including whatever decode popped this cycle (that pop still counts as taken).
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= ADDR_WIDTH'(RESET_PC);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_addr;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_instr};
        end
    end

    assign head            = queue_mem[rd_ptr];
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.halted      = (state_q == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed and random stimulus for fetch_unit against a queue-based reference model.
// Latency : model is updated at each rising edge and compared 1 time unit later.
// Backpressure: instr_ready is driven directly, held low in directed phases and random later.
module tb_fetch_unit;
    localparam int AW = 9;
    localparam int DW = 12;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] imem [512];
    assign bus.imem_instr = imem[bus.imem_addr];

    // Reference model: a plain queue of fetched entries, a PC and a halt flag.
    ent_t          mq[$];
    logic [AW-1:0] mpc;
    bit            mhalt;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [AW-1:0] ra,
                        input bit hr, input bit rdy);
        bit pop;
        bit push;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.halt_req       = hr;
        bus.instr_ready    = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mpc   = '0;
            mhalt = 0;
        end else begin
            pop = (mq.size() != 0) && rdy;
            if (rv) begin
                mq.delete();
                mpc   = ra;
                mhalt = hr;
            end else begin
                push = !mhalt && !hr && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back('{pc: mpc, ins: imem[mpc]});
                    mpc = mpc + 9'd1;
                end
                if (hr) mhalt = 1;
            end
        end
        #1;
        check("imem_addr", 32'(bus.imem_addr), 32'(mpc));
        check("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
        check("halted", 32'(bus.halted), 32'(mhalt));
        if (mq.size() != 0) begin
            check("instr", 32'(bus.instr), 32'(mq[0].ins));
            check("instr_pc", 32'(bus.instr_pc), 32'(mq[0].pc));
        end
    endtask

    initial begin
        logic [DW-1:0] seq [4];
        bit            r;
        bit            rv;
        bit            hr;
        bit            rdy;
        logic [AW-1:0] ra;

        seq = '{12'h041, 12'h28B, 12'hA01, 12'h123};
        for (int i = 0; i < 512; i++) imem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) imem[i] = seq[i];
        bus.redirect_valid = 0;
        bus.redirect_addr  = '0;
        bus.halt_req       = 0;
        bus.instr_ready    = 0;

        // Reset state.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_addr", 32'(bus.imem_addr), 32'h0);

        // Streaming with ready high: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            check("seq_instr", 32'(bus.instr), 32'(seq[i]));
            check("seq_pc", 32'(bus.instr_pc), i);
        end

        // Mid-operation reset, then backpressure.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("bp_addr", 32'(bus.imem_addr), 32'h2);
        check("bp_instr", 32'(bus.instr), 32'h041);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            check("bp_drain_pc", 32'(bus.instr_pc), i + 1);
        end

        // Redirect while full.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 9'h100, 0, 1);
        check("redir_valid", 32'(bus.instr_valid), 32'h0);
        check("redir_addr", 32'(bus.imem_addr), 32'h100);
        step(0, 0, 0, 0, 1);
        check("redir_pc", 32'(bus.instr_pc), 32'h100);
        step(0, 0, 0, 0, 1);
        check("redir_pc2", 32'(bus.instr_pc), 32'h101);

        // Wrap.
        step(0, 1, 9'h1FF, 0, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_pc0", 32'(bus.instr_pc), 32'h1FF);
        step(0, 0, 0, 0, 1);
        check("wrap_pc1", 32'(bus.instr_pc), 32'h000);

        // Halt at PC 5 with entries 3,4 queued.
        step(0, 1, 9'h003, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_addr", 32'(bus.imem_addr), 32'h5);
        step(0, 0, 0, 0, 1);
        check("halt_drain", 32'(bus.instr_pc), 32'h4);
        step(0, 0, 0, 1, 1);
        check("halt_empty", 32'(bus.instr_valid), 32'h0);
        step(0, 1, 9'h020, 0, 1);
        check("resume_flag", 32'(bus.halted), 32'h0);
        step(0, 0, 0, 0, 1);
        check("resume_pc", 32'(bus.instr_pc), 32'h020);

        // Redirect and halt together.
        step(0, 1, 9'h030, 1, 1);
        check("rh_halted", 32'(bus.halted), 32'h1);
        check("rh_addr", 32'(bus.imem_addr), 32'h030);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        check("rh_nopush", 32'(bus.instr_valid), 32'h0);
        step(0, 1, 9'h040, 0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            hr  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            ra  = AW'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0) ra = 9'h1FF;
            step(r, rv, ra, hr, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter, drives the instruction memory address, and buffers fetched instructions in a small queue for the decode stage. It sits directly upstream of the instruction memory and directly downstream of branch resolution. It accepts PC redirects from taken branches and supports halt/resume. The instruction memory is a combinational read: the word for `imem_addr` is valid in the same cycle.

## Interface
- `ADDR_WIDTH`, 9: PC / instruction-memory address width; PC wraps modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 12: instruction width.
- `FIFO_DEPTH`, 2: fetch queue entries; power of two, ≥2.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH  address to instruction memory; always equals internal `fetch_pc`.
- `imem_instr`  in  DATA_WIDTH  instruction read combinationally at `imem_addr`.
- `redirect_valid`  in  1  one-cycle pulse: taken branch/jump.
- `redirect_addr`  in  ADDR_WIDTH  new PC on redirect.
- `halt_req`  in  1  one-cycle pulse: stop fetching.
- `instr_valid`  out  1  queue head holds a valid instruction.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instr`  out  DATA_WIDTH  queue head instruction.
- `instr_pc`  out  ADDR_WIDTH  address the head was fetched from.
- `halted`  out  1  high while in HALT state.

## Operation
- State machine with two states, RUN and HALT. Reset enters RUN.
- Queue entries hold {pc, instr}. The head drives `instr`/`instr_pc`. `instr_valid` = (count != 0).
- pop = `instr_valid` & `instr_ready`.
- push = RUN & !`redirect_valid` & !`halt_req` & (count < FIFO_DEPTH | pop).
- On push, the queue stores {`fetch_pc`, `imem_instr`} at the tail and `fetch_pc` increments by 1. Arithmetic is ADDR_WIDTH bits; 2^ADDR_WIDTH−1 wraps to 0.
- Queue full and no pop: no push, and `fetch_pc` holds.
- Simultaneous push and pop when full: both occur and count is unchanged.
- Simultaneous push and pop at count 1: the new entry becomes the head.
- Redirect (any state) has highest priority:
  - the queue is flushed (count←0, pointers reset) and `fetch_pc`←`redirect_addr`;
  - a pop in the same cycle still counts as accepted by decode;
  - the next state is RUN, unless `halt_req` is also high, in which case the next state is HALT.
- `halt_req` in RUN without redirect: next state HALT, no push that cycle, and `fetch_pc` holds. Queued entries remain and drain normally via pop.
- `halt_req` in HALT is ignored.
- HALT exits only on `redirect_valid`.
- Queue count never exceeds FIFO_DEPTH. Pop is never performed on an empty queue.

## Timing
- Reset values: `fetch_pc`/`imem_addr` = RESET_PC, count = 0, `instr_valid` = 0, `halted` = 0, state RUN. `instr`/`instr_pc` are don't-care while `instr_valid` = 0.
- Reset asserted mid-operation discards the queue, state, and PC at that edge.
- First push happens at the first edge with `rst` low. `instr_valid` rises after that edge with `instr_pc` = RESET_PC.
- Fetch-to-decode latency is 1 cycle: an instruction read in cycle N is visible at the queue head in cycle N+1 if the queue was empty.
- Redirect sampled at edge E:
  - `instr_valid` = 0 after E, and `imem_addr` = `redirect_addr` after E;
  - the push at edge E+1 makes `instr_valid` = 1 after E+1 with `instr_pc` = `redirect_addr`;
  - total redirect penalty is 2 cycles.
- `halted` is registered: it rises on the edge that samples `halt_req` and falls on the edge that samples the exiting redirect.
- Steady state with `instr_ready` held high: one instruction per cycle, sequential PCs.

## Test plan
- Reset release, preload mem[0..3] = 0x041, 0x28B, 0xA01, 0x123, `instr_ready`=1 -> from cycle 1, `instr`/`instr_pc` sequence is 0x041/0, 0x28B/1, 0xA01/2, 0x123/3, one per cycle.
- Backpressure: `instr_ready`=0 for 5 cycles after reset -> count saturates at 2, `imem_addr` holds at 2, `instr` stays 0x041. Then `instr_ready`=1 -> PCs 0, 1, 2 are delivered with no gap and no duplicate.
- Redirect to 0x100 while queue full and `instr_ready`=1 -> next cycle `instr_valid`=0 and `imem_addr`=0x100. The cycle after, `instr_pc`=0x100. No stale PCs appear after the flush.
- Wrap: redirect to 0x1FF -> delivered PCs are 0x1FF then 0x000.
- Halt: pulse `halt_req` at PC 5 with `instr_ready`=0 -> `halted`=1, `imem_addr` holds 5, and 2 queued entries drain when ready rises. Redirect to 0x020 -> `halted`=0, and `instr_pc`=0x020 two cycles later.
- Simultaneous `halt_req` and `redirect_valid` to 0x030 -> queue flushed, `imem_addr`=0x030, `halted`=1, and no push occurs until a further redirect.
